// File: rtl/mandelbrot_sched_pkg.sv
//------------------------------------------------------------------------------
// Module : mandelbrot_sched_pkg
// Brief  : Shared defaults and helpers for the Mandelbrot job scheduler.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mandelbrot_sched_pkg;

  localparam int c_NE_DEFAULT  = 4;
  localparam int c_FPW_DEFAULT = 54;
  localparam int c_IW_DEFAULT  = 8;
  localparam int c_AW_DEFAULT  = 12;
  localparam int c_OCW_DEFAULT = 16;

  // Pointer width for an n-entry round-robin; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mandelbrot_rr_arb.sv
//------------------------------------------------------------------------------
// Module : mandelbrot_rr_arb
// Brief  : Combinational round-robin picker: first request at or after i_base.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mandelbrot_rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_base,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_k;

  // Walk from the farthest offset back to i_base so the nearest request wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = (int'(i_base) + i) % N;
      if (i_req[w_k]) begin
        o_gnt      = '0;
        o_gnt[w_k] = 1'b1;
        o_idx      = PW'(w_k);
      end
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/mandelbrot_sched.sv
//------------------------------------------------------------------------------
// Module : mandelbrot_sched
// Brief  : Round-robin job dispatch to NE calc engines and result merge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mandelbrot_sched
  import mandelbrot_sched_pkg::*;
#(
  parameter int NE  = c_NE_DEFAULT,
  parameter int FPW = c_FPW_DEFAULT,
  parameter int IW  = c_IW_DEFAULT,
  parameter int AW  = c_AW_DEFAULT,
  parameter int OCW = c_OCW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [FPW-1:0]   in_x,
  input  logic [FPW-1:0]   in_y,
  input  logic [AW-1:0]    in_adr,
  output logic [NE-1:0]    eng_in_vld,
  input  logic [NE-1:0]    eng_in_rdy,
  output logic [FPW-1:0]   eng_x,
  output logic [FPW-1:0]   eng_y,
  output logic [AW-1:0]    eng_adr,
  input  logic [NE-1:0]    eng_out_vld,
  output logic [NE-1:0]    eng_out_rdy,
  input  logic [NE*IW-1:0] eng_niter,
  input  logic [NE*AW-1:0] eng_adr_o,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [IW-1:0]    out_dat,
  output logic [AW-1:0]    out_adr,
  output logic [OCW-1:0]   busy_cnt,
  output logic             idle
);

  localparam int PW = ptr_width(NE);

  logic [PW-1:0]  r_disp_ptr;
  logic [PW-1:0]  r_col_ptr;
  logic           r_out_vld;
  logic [IW-1:0]  r_out_dat;
  logic [AW-1:0]  r_out_adr;
  logic [OCW-1:0] r_busy_cnt;

  logic [NE-1:0]  w_disp_gnt;
  logic [PW-1:0]  w_disp_idx;
  logic           w_disp_any;
  logic [NE-1:0]  w_col_gnt;
  logic [PW-1:0]  w_col_idx;
  logic           w_col_any;

  logic           w_en;
  logic           w_disp_xfer;
  logic           w_load;
  logic           w_out_hs;
  logic [OCW-1:0] w_busy_nxt;

  function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NE - 1)) ? '0 : p + PW'(1);
  endfunction

  mandelbrot_rr_arb #(.N(NE), .PW(PW)) u_disp_arb (
    .i_req  (eng_in_rdy),
    .i_base (r_disp_ptr),
    .o_gnt  (w_disp_gnt),
    .o_idx  (w_disp_idx),
    .o_any  (w_disp_any)
  );

  mandelbrot_rr_arb #(.N(NE), .PW(PW)) u_col_arb (
    .i_req  (eng_out_vld),
    .i_base (r_col_ptr),
    .o_gnt  (w_col_gnt),
    .o_idx  (w_col_idx),
    .o_any  (w_col_any)
  );

  // Handshakes are also suppressed while in reset, since engines share rst.
  assign w_en        = clk_en && rst;
  assign in_rdy      = w_en && w_disp_any;
  assign eng_in_vld  = (w_en && in_vld) ? w_disp_gnt : '0;
  assign w_disp_xfer = w_en && in_vld && w_disp_any;

  assign eng_x   = in_x;
  assign eng_y   = in_y;
  assign eng_adr = in_adr;

  assign w_load      = w_en && (!r_out_vld || out_rdy);
  assign eng_out_rdy = (w_load && w_col_any) ? w_col_gnt : '0;
  assign w_out_hs    = w_en && r_out_vld && out_rdy;

  always_comb begin
    w_busy_nxt = r_busy_cnt;
    unique case ({w_disp_xfer, w_out_hs})
      2'b10:   if (r_busy_cnt != '1) w_busy_nxt = r_busy_cnt + OCW'(1);
      2'b01:   if (r_busy_cnt != '0) w_busy_nxt = r_busy_cnt - OCW'(1);
      default: w_busy_nxt = r_busy_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp_ptr <= '0;
      r_col_ptr  <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_adr  <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_disp_xfer) r_disp_ptr <= f_ptr_next(w_disp_idx);
      if (w_load) begin
        r_out_vld <= w_col_any;
        if (w_col_any) begin
          r_out_dat <= eng_niter[int'(w_col_idx)*IW +: IW];
          r_out_adr <= eng_adr_o[int'(w_col_idx)*AW +: AW];
          r_col_ptr <= f_ptr_next(w_col_idx);
        end
      end
      // A result leaving with nothing outstanding means an engine invented a job.
      if (w_out_hs && !w_disp_xfer) assert (r_busy_cnt != '0);
      r_busy_cnt <= w_busy_nxt;
    end
  end

  assign out_vld  = r_out_vld;
  assign out_dat  = r_out_dat;
  assign out_adr  = r_out_adr;
  assign busy_cnt = r_busy_cnt;
  assign idle     = (r_busy_cnt == '0) && !r_out_vld;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_sched.sv
//------------------------------------------------------------------------------
// Module : tb_mandelbrot_sched
// Brief  : Randomized bench for mandelbrot_sched with engine and scheduler model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mandelbrot_sched;

  localparam int NE  = 4;
  localparam int FPW = 54;
  localparam int IW  = 8;
  localparam int AW  = 12;
  localparam int OCW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clk_en;
  logic             in_vld;
  logic             in_rdy;
  logic [FPW-1:0]   in_x;
  logic [FPW-1:0]   in_y;
  logic [AW-1:0]    in_adr;
  logic [NE-1:0]    eng_in_vld;
  logic [NE-1:0]    eng_in_rdy;
  logic [FPW-1:0]   eng_x;
  logic [FPW-1:0]   eng_y;
  logic [AW-1:0]    eng_adr;
  logic [NE-1:0]    eng_out_vld;
  logic [NE-1:0]    eng_out_rdy;
  logic [NE*IW-1:0] eng_niter;
  logic [NE*AW-1:0] eng_adr_o;
  logic             out_rdy;
  logic             out_vld;
  logic [IW-1:0]    out_dat;
  logic [AW-1:0]    out_adr;
  logic [OCW-1:0]   busy_cnt;
  logic             idle;

  always #5 clk = ~clk;

  mandelbrot_sched #(.NE(NE), .FPW(FPW), .IW(IW), .AW(AW), .OCW(OCW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_adr      (in_adr),
    .eng_in_vld  (eng_in_vld),
    .eng_in_rdy  (eng_in_rdy),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_adr     (eng_adr),
    .eng_out_vld (eng_out_vld),
    .eng_out_rdy (eng_out_rdy),
    .eng_niter   (eng_niter),
    .eng_adr_o   (eng_adr_o),
    .out_rdy     (out_rdy),
    .out_vld     (out_vld),
    .out_dat     (out_dat),
    .out_adr     (out_adr),
    .busy_cnt    (busy_cnt),
    .idle        (idle)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scheduler model: pointers, held output, outstanding count.
  int               m_dptr, m_cptr, m_busy;
  bit               m_vld;
  logic [IW-1:0]    m_dat;
  logic [AW-1:0]    m_adr;
  // Engine model: each engine queues job addresses and returns them in order.
  logic [AW-1:0]    eq [NE][$];
  bit               fixed_niter = 1'b0;
  int               dir_vld_exp = -1;
  int               dir_dat_exp = -1;

  function automatic int first_from(input logic [NE-1:0] req, input int ptr);
    for (int off = 0; off < NE; off++)
      if (req[(ptr + off) % NE]) return (ptr + off) % NE;
    return -1;
  endfunction

  function automatic logic [IW-1:0] calc(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic model_reset();
    m_dptr = 0; m_cptr = 0; m_busy = 0; m_vld = 1'b0; m_dat = '0; m_adr = '0;
    for (int k = 0; k < NE; k++) eq[k].delete();
  endtask

  task automatic drive(input bit en, input bit iv, input logic [NE-1:0] rdy,
                       input logic [NE-1:0] omask, input bit ordy, input logic [AW-1:0] adr);
    @(negedge clk);
    clk_en     = en;
    in_vld     = iv;
    in_x       = FPW'({$urandom(), $urandom()});
    in_y       = FPW'({$urandom(), $urandom()});
    in_adr     = adr;
    eng_in_rdy = rdy;
    out_rdy    = ordy;
    for (int k = 0; k < NE; k++) begin
      eng_out_vld[k] = omask[k] && (eq[k].size() > 0);
      if (eq[k].size() > 0) begin
        eng_adr_o[k*AW +: AW] = eq[k][0];
        eng_niter[k*IW +: IW] = fixed_niter ? IW'(k + 10) : calc(eq[k][0]);
      end else begin
        eng_adr_o[k*AW +: AW] = AW'($urandom());
        eng_niter[k*IW +: IW] = IW'($urandom());
      end
    end
  endtask

  task automatic step();
    logic [NE-1:0] one, e_in_vld, e_out_rdy;
    int dg, cg;
    bit load, hs, xfer;
    one = 1;
    #1;
    dg = first_from(eng_in_rdy, m_dptr);
    e_in_vld = (clk_en && in_vld && dg >= 0) ? (one << dg) : '0;
    load = clk_en && (!m_vld || out_rdy);
    cg = first_from(eng_out_vld, m_cptr);
    e_out_rdy = (load && cg >= 0) ? (one << cg) : '0;
    hs = clk_en && m_vld && out_rdy;
    chk("in_rdy", in_rdy, clk_en && dg >= 0);
    chk("eng_in_vld", eng_in_vld, e_in_vld);
    chk("eng_out_rdy", eng_out_rdy, e_out_rdy);
    chk("eng_x", eng_x, in_x);
    chk("eng_y", eng_y, in_y);
    chk("eng_adr", eng_adr, in_adr);
    if (dir_vld_exp >= 0) chk("rr_dispatch", eng_in_vld, dir_vld_exp);
    xfer = (e_in_vld != '0);
    if (xfer) begin
      eq[dg].push_back(in_adr);
      m_dptr = (dg + 1) % NE;
    end
    if (load) begin
      if (cg >= 0) begin
        m_vld = 1'b1;
        m_dat = eng_niter[cg*IW +: IW];
        m_adr = eng_adr_o[cg*AW +: AW];
        m_cptr = (cg + 1) % NE;
        void'(eq[cg].pop_front());
      end else begin
        m_vld = 1'b0;
      end
    end
    if (xfer && !hs && m_busy < (1 << OCW) - 1) m_busy++;
    if (hs && !xfer && m_busy > 0) m_busy--;
    @(posedge clk);
    #1;
    chk("out_vld", out_vld, m_vld);
    chk("out_dat", out_dat, m_dat);
    chk("out_adr", out_adr, m_adr);
    chk("busy_cnt", busy_cnt, m_busy);
    chk("idle", idle, (m_busy == 0) && !m_vld);
    if (dir_dat_exp >= 0) chk("col_dat", out_dat, dir_dat_exp);
  endtask

  task automatic reset_phase(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      clk_en      = 1'($urandom());
      in_vld      = 1'($urandom());
      eng_in_rdy  = NE'($urandom());
      eng_out_vld = NE'($urandom());
      out_rdy     = 1'($urandom());
      #1;
      chk("rst_eng_in_vld", eng_in_vld, 0);
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_eng_out_rdy", eng_out_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_busy_cnt", busy_cnt, 0);
      chk("rst_idle", idle, 1);
    end
    model_reset();
    @(negedge clk);
    eng_out_vld = '0;
    in_vld      = 1'b0;
    rst         = 1'b1;
  endtask

  task automatic random_phase(input int cycles);
    int freeze = 0;
    logic [NE-1:0] rdy, om;
    for (int i = 0; i < cycles; i++) begin
      if (freeze == 0 && $urandom_range(0, 39) == 0) freeze = 3;
      for (int k = 0; k < NE; k++) begin
        rdy[k] = (eq[k].size() < 3) && ($urandom_range(0, 3) != 0);
        om[k]  = ($urandom_range(0, 3) != 0);
      end
      drive(freeze == 0 && $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
            rdy, om, $urandom_range(0, 9) < 7, AW'($urandom()));
      if (freeze > 0) freeze--;
      step();
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_busy > 0 || m_vld) && guard < 300) begin
      drive(1'b1, 1'b0, '1, '1, 1'b1, '0);
      step();
      guard++;
    end
    chk("drain_done", (m_busy == 0 && !m_vld), 1);
    chk("idle_after_drain", idle, 1);
    chk("busy_after_drain", busy_cnt, 0);
  endtask

  logic [NE-1:0] rr_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int dat_tab [4] = '{10, 10, 11, 12};
  bit ordy_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    clk_en = 1'b0; in_vld = 1'b0; in_x = '0; in_y = '0; in_adr = '0;
    eng_in_rdy = '0; eng_out_vld = '0; eng_niter = '0; eng_adr_o = '0; out_rdy = 1'b0;
    model_reset();
    reset_phase(4);

    // Back-to-back dispatch with every engine ready.
    for (int i = 0; i < 8; i++) begin
      dir_vld_exp = int'(rr_tab[i]);
      drive(1'b1, 1'b1, '1, '0, 1'b0, AW'(i));
      step();
    end
    chk("busy_after_8", busy_cnt, 8);

    // Advance pointer to engine 2, then skip busy engine 2.
    dir_vld_exp = 1; drive(1'b1, 1'b1, '1, '0, 1'b0, 12'd8); step();
    dir_vld_exp = 2; drive(1'b1, 1'b1, '1, '0, 1'b0, 12'd9); step();
    dir_vld_exp = 8; drive(1'b1, 1'b1, 4'b1011, '0, 1'b0, 12'd10); step();
    dir_vld_exp = 1; drive(1'b1, 1'b1, 4'b1011, '0, 1'b0, 12'd11); step();
    dir_vld_exp = -1;
    chk("busy_after_12", busy_cnt, 12);

    // Collect fairness with backpressure.
    fixed_niter = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir_dat_exp = dat_tab[i];
      drive(1'b1, 1'b0, '0, '1, ordy_tab[i], '0);
      step();
    end
    dir_dat_exp = -1;
    fixed_niter = 1'b0;
    chk("busy_after_collect", busy_cnt, 10);

    // Dispatch and output handshake in the same cycle.
    drive(1'b1, 1'b1, '1, '0, 1'b1, 12'd20);
    step();
    chk("busy_simul", busy_cnt, 10);

    drain();
    random_phase(600);
    drain();

    random_phase(150);
    reset_phase(3);
    random_phase(200);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
